// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, fetch/halt FSM and a one-entry output register
// handshaked to decode with if_valid/id_ready.
//
// state | meaning
// IDLE  | first cycle after reset, no capture
// FETCH | capture read_data whenever the output slot is free
// HALT  | HALT_WORD captured, PC frozen until a redirect
module instruction_fetch #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] inst_address,
    input  logic [31:0] read_data,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic [31:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid,
    input  logic        id_ready,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [15:0] LAST_PC = 16'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    state_t      state, state_next;
    logic [15:0] pc, pc_next, pc_inc;
    logic        capture;

    assign inst_address = pc;
    assign halted       = (state == HALT);
    // Out-of-range redirect targets also wrap to zero on their next increment
    assign pc_inc       = (pc >= LAST_PC) ? 16'h0000 : pc + 16'h0001;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                state_next = FETCH;
                if (redirect_valid) pc_next = redirect_pc;
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end else if (!if_valid || id_ready) begin
                    capture = 1'b1;
                    pc_next = pc_inc;
                    if (read_data == HALT_WORD) state_next = HALT;
                end
            end
            HALT: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_instr    <= 32'h0000_0000;
            if_pc       <= 16'h0000;
            if_valid    <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (capture) begin
                if_instr <= read_data;
                if_pc    <= pc;
                if_valid <= 1'b1;
            end else if (id_ready) begin
                if_valid <= 1'b0;
            end
            if (capture && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'h0001;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a memory model drives read_data, a scoreboard
// queue holds the (pc, instr) pairs expected at each decode transfer.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] inst_address;
    logic [31:0] read_data;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        id_ready = 1'b1;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:255];
    logic [47:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n), .inst_address(inst_address), .read_data(read_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .if_instr(if_instr),
        .if_pc(if_pc), .if_valid(if_valid), .id_ready(id_ready), .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    assign read_data = mem[inst_address[7:0]];

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic [15:0] pc, input logic [31:0] instr);
        sb_q.push_back({pc, instr});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_instr"}, {16'h0, if_instr}, 48'h0);
        check({tag, "_pc"}, {32'h0, if_pc}, 48'h0);
        check({tag, "_valid"}, {47'h0, if_valid}, 48'h0);
        check({tag, "_halted"}, {47'h0, halted}, 48'h0);
        check({tag, "_count"}, {32'h0, fetch_count}, 48'h0);
        check({tag, "_addr"}, {32'h0, inst_address}, 48'h0);
    endtask

    // Transfers are sampled mid-cycle; inputs only change 1ns after a rising edge
    always @(negedge clk) begin
        if (rst_n && if_valid && id_ready) begin
            if (sb_q.size() == 0) begin
                check("xfer_unexpected", {if_pc, if_instr}, 48'hx);
            end else begin
                check("xfer", {if_pc, if_instr}, sb_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | 32'(i);
        mem[0] = 32'h2000_0004;
        mem[1] = 32'h1111_1111;

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) expect_xfer(16'(i), (i == 0) ? 32'h2000_0004 :
                                                        (i == 1) ? 32'h1111_1111 :
                                                        32'hA000_0000 | 32'(i));

        tick();
        check("idle_valid", {47'h0, if_valid}, 48'h0);
        check("idle_addr", {32'h0, inst_address}, 48'h0);
        tick();
        check("edge2", {if_pc, if_instr}, {16'h0000, 32'h2000_0004});
        tick();
        check("edge3", {if_pc, if_instr}, {16'h0001, 32'h1111_1111});
        check("edge3_count", {32'h0, fetch_count}, 48'd2);
        repeat (4) tick();
        check("pre_stall_pc", {32'h0, if_pc}, 48'd5);

        id_ready = 1'b0;
        check("stall_count0", {32'h0, fetch_count}, 48'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", {32'h0, if_pc}, 48'd5);
            check("stall_addr", {32'h0, inst_address}, 48'd6);
            check("stall_count", {32'h0, fetch_count}, 48'd6);
            check("stall_valid", {47'h0, if_valid}, 48'd1);
        end
        id_ready = 1'b1;
        tick();
        check("post_stall_pc", {if_pc, if_instr}, {16'd6, 32'hA000_0006});

        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0040;
        tick();
        check("redir_valid", {47'h0, if_valid}, 48'h0);
        check("redir_addr", {32'h0, inst_address}, 48'h40);
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        expect_xfer(16'h0040, 32'hA000_0040);
        tick();
        check("redir_pc", {if_pc, if_instr}, {16'h0040, 32'hA000_0040});
        check("redir_count", {32'h0, fetch_count}, 48'd8);

        redirect_valid = 1'b1;
        redirect_pc = 16'd255;
        tick();
        check("wrap_redir_addr", {32'h0, inst_address}, 48'd255);
        redirect_valid = 1'b0;
        expect_xfer(16'd255, 32'hA000_00FF);
        expect_xfer(16'd0, 32'h2000_0004);
        tick();
        check("wrap_pc255", {32'h0, if_pc}, 48'd255);
        check("wrap_addr0", {32'h0, inst_address}, 48'd0);
        tick();
        check("wrap_pc0", {32'h0, if_pc}, 48'd0);

        mem[3] = 32'hFFFF_FFFF;
        expect_xfer(16'd1, 32'h1111_1111);
        expect_xfer(16'd2, 32'hA000_0002);
        expect_xfer(16'd3, 32'hFFFF_FFFF);
        tick();
        tick();
        check("pre_halt_halted", {47'h0, halted}, 48'h0);
        tick();
        check("halt_word", {if_pc, if_instr}, {16'd3, 32'hFFFF_FFFF});
        check("halt_flag", {47'h0, halted}, 48'h1);
        check("halt_addr", {32'h0, inst_address}, 48'd4);
        tick();
        check("halt_drain", {47'h0, if_valid}, 48'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("halt_hold", {31'h0, halted, inst_address}, {31'h0, 1'b1, 16'd4});
        end
        check("halt_count", {32'h0, fetch_count}, 48'd13);

        redirect_valid = 1'b1;
        redirect_pc = 16'h0000;
        tick();
        check("unhalt_flag", {47'h0, halted}, 48'h0);
        check("unhalt_addr", {32'h0, inst_address}, 48'h0);
        redirect_valid = 1'b0;
        expect_xfer(16'd0, 32'h2000_0004);
        expect_xfer(16'd1, 32'h1111_1111);
        expect_xfer(16'd2, 32'hA000_0002);
        tick();
        check("resume_pc", {if_pc, if_instr}, {16'd0, 32'h2000_0004});
        tick();
        tick();
        tick();
        id_ready = 1'b0;
        check("rehalt", {31'h0, halted, if_pc}, {31'h0, 1'b1, 16'd3});
        check("rehalt_valid", {47'h0, if_valid}, 48'h1);

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        id_ready = 1'b1;
        expect_xfer(16'd0, 32'h2000_0004);
        tick();
        check("post_reset_edge1", {47'h0, if_valid}, 48'h0);
        tick();
        check("post_reset_edge2", {if_pc, if_instr}, {16'd0, 32'h2000_0004});
        check("post_reset_count", {32'h0, fetch_count}, 48'd1);
        @(negedge clk);
        #1;
        check("sb_empty", 48'(sb_q.size()), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
